// File: rtl/rom_arbiter.sv
// Two-port arbiter sharing one combinational-read ROM between instruction fetch
// and the data path's read-only accesses. Data has priority; a streak limiter
// hands the ROM to fetch after STREAK_MAX consecutive contested data grants.
// Responses are registered and routed back to the owner one cycle later.
module rom_arbiter #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_OFFSET = '0,
    parameter int unsigned           MEM_SIZE   = 65536,
    parameter int unsigned           STREAK_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_rerr_o,

    input  logic                  d_req_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_rerr_o,

    output logic                  rom_ce_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i
);

    localparam int unsigned StreakWidth = $clog2(STREAK_MAX + 1);
    localparam logic [StreakWidth-1:0] StreakSat = StreakWidth'(STREAK_MAX);
    // One extra bit so OFFSET + SIZE cannot wrap at the top of the address space.
    localparam logic [ADDR_WIDTH:0] WinLo = {1'b0, MEM_OFFSET};
    localparam logic [ADDR_WIDTH:0] WinHi = WinLo + (ADDR_WIDTH + 1)'(MEM_SIZE);

    logic [StreakWidth-1:0] streak_q, streak_d;
    logic                   rvalid_q, rvalid_d;
    logic                   owner_q, owner_d;   // 0 = fetch, 1 = data
    logic                   rerr_q, rerr_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

    logic                   if_gnt, d_gnt, any_gnt, fetch_turn, in_range;
    logic [ADDR_WIDTH-1:0]  gnt_addr;
    logic [ADDR_WIDTH:0]    gnt_addr_ext;

    // Grant decision and window check on the selected address.
    always_comb begin
        fetch_turn   = (streak_q == StreakSat);
        d_gnt        = ~rst_i & d_req_i & ~(if_req_i & fetch_turn);
        if_gnt       = ~rst_i & if_req_i & ~d_gnt;
        any_gnt      = if_gnt | d_gnt;
        gnt_addr     = d_gnt ? d_addr_i : if_addr_i;
        gnt_addr_ext = {1'b0, gnt_addr};
        in_range     = (gnt_addr_ext >= WinLo) && (gnt_addr_ext < WinHi);
    end

    // Next-state for the streak counter and the response registers.
    always_comb begin
        streak_d = '0;
        rvalid_d = any_gnt;
        owner_d  = owner_q;
        rerr_d   = rerr_q;
        rdata_d  = rdata_q;
        // Only data wins that keep fetch waiting extend the streak.
        if (d_gnt && if_req_i) begin
            streak_d = fetch_turn ? streak_q : streak_q + 1'b1;
        end
        if (any_gnt) begin
            owner_d = d_gnt;
            rerr_d  = ~in_range;
            rdata_d = in_range ? rom_data_i : '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            streak_q <= '0;
            rvalid_q <= 1'b0;
            owner_q  <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            streak_q <= streak_d;
            rvalid_q <= rvalid_d;
            owner_q  <= owner_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
        end
    end

    // Gating with rst_i drops a response whose grant preceded a reset cycle.
    always_comb begin
        if_gnt_o    = if_gnt;
        d_gnt_o     = d_gnt;
        rom_addr_o  = gnt_addr;
        rom_ce_o    = any_gnt & in_range;
        if_rvalid_o = rvalid_q & ~owner_q & ~rst_i;
        d_rvalid_o  = rvalid_q & owner_q & ~rst_i;
        if_rerr_o   = if_rvalid_o & rerr_q;
        d_rerr_o    = d_rvalid_o & rerr_q;
        if_rdata_o  = rdata_q;
        d_rdata_o   = rdata_q;
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: the stimulus side predicts each grant from
// the arbitration rules and queues the expected response; an independent
// monitor compares whatever the DUT returns against the queue head.
module tb_rom_arbiter;

    localparam int unsigned StreakMax = 4;
    localparam longint      WinBase   = 64'h0;
    localparam longint      WinSize   = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0;
    logic        if_gnt, if_rvalid, if_rerr, d_gnt, d_rvalid, d_rerr, rom_ce;
    logic [31:0] if_rdata, d_rdata, rom_addr, rom_data;

    always #5 clk = ~clk;

    // Bench ROM: word at address A is A + 3.
    assign rom_data = rom_addr + 32'd3;

    rom_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_OFFSET (32'h0000_0000),
        .MEM_SIZE   (65536),
        .STREAK_MAX (StreakMax)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .if_rerr_o   (if_rerr),
        .d_req_i     (d_req),
        .d_addr_i    (d_addr),
        .d_gnt_o     (d_gnt),
        .d_rvalid_o  (d_rvalid),
        .d_rdata_o   (d_rdata),
        .d_rerr_o    (d_rerr),
        .rom_ce_o    (rom_ce),
        .rom_addr_o  (rom_addr),
        .rom_data_i  (rom_data)
    );

    typedef struct {
        bit          owner;  // 1 = data port
        logic [31:0] data;
        bit          err;
        int          due;
    } resp_t;

    resp_t q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    // Reference state: consecutive cycles fetch has lost to data.
    int    fetch_losses = 0;
    bit    exp_if_gnt, exp_d_gnt;
    bit    act_d_gnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    function automatic bit in_window(input logic [31:0] a);
        longint la = longint'(a);
        return (la >= WinBase) && (la < WinBase + WinSize);
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_fffc;
            1:       return 32'h0001_0000;
            2:       return $urandom & 32'hffff_fffc;
            default: return 32'($urandom_range(0, 16383)) << 2;
        endcase
    endfunction

    // One clock: predict and check grants mid-cycle, queue the response,
    // then return just after the next rising edge so inputs can change.
    task automatic cycle();
        logic [31:0] a;
        bit          fetch_starved;
        @(negedge clk);
        fetch_starved = (fetch_losses >= StreakMax);
        exp_d_gnt  = !rst && d_req && !(if_req && fetch_starved);
        exp_if_gnt = !rst && if_req && !exp_d_gnt;
        act_d_gnt  = d_gnt;
        check("if_gnt", if_gnt, exp_if_gnt);
        check("d_gnt", d_gnt, exp_d_gnt);
        if (exp_if_gnt || exp_d_gnt) begin
            resp_t r;
            a = exp_d_gnt ? d_addr : if_addr;
            check("rom_addr", rom_addr, a);
            check("rom_ce", rom_ce, in_window(a));
            r.owner = exp_d_gnt;
            r.err   = !in_window(a);
            r.data  = in_window(a) ? a + 32'd3 : 32'd0;
            r.due   = cyc + 1;
            q.push_back(r);
        end else begin
            check("rom_ce_idle", rom_ce, 1'b0);
        end
        if (rst || !(exp_d_gnt && if_req)) fetch_losses = 0;
        else fetch_losses++;
        @(posedge clk);
        #1;
    endtask

    // Assert reset now; any response not yet delivered is lost.
    task automatic assert_reset();
        rst = 1'b1;
        while (q.size() > 0 && q[$].due >= cyc) void'(q.pop_back());
    endtask

    // Monitor: compare every cycle against the scoreboard head.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            resp_t e;
            e = q.pop_front();
            check("if_rvalid", if_rvalid, !e.owner);
            check("d_rvalid", d_rvalid, e.owner);
            check("if_rerr", if_rerr, !e.owner && e.err);
            check("d_rerr", d_rerr, e.owner && e.err);
            check("if_rdata", if_rdata, e.data);
            check("d_rdata", d_rdata, e.data);
        end else begin
            check("no_resp", {if_rvalid, d_rvalid, if_rerr, d_rerr}, 4'b0);
        end
    end

    initial begin
        // Reset held two cycles with both requesting.
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1;
        if_addr = 32'h100; d_addr = 32'h200;
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        check("first_after_reset_data", act_d_gnt, 1'b1);
        if_req = 1'b0; d_req = 1'b0;
        cycle();

        // Single fetch: address 0x10 returns 0x13.
        if_req = 1'b1; if_addr = 32'h10;
        cycle();
        if_req = 1'b0;
        cycle(); cycle();

        // Contention from a cleared streak: D,D,D,D,F repeating.
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            cycle();
            check("contend_seq", act_d_gnt, (i % 5) != 4);
            if (exp_if_gnt) if_addr = 32'($urandom_range(0, 16383)) << 2;
            if (exp_d_gnt)  d_addr  = 32'($urandom_range(0, 16383)) << 2;
        end
        if_req = 1'b0; d_req = 1'b0;
        cycle();

        // Out of window data read.
        d_req = 1'b1; d_addr = 32'h0001_0000;
        cycle();
        d_req = 1'b0;
        cycle();

        // Pipelined alternation: fetch then data, no gap.
        if_req = 1'b1; if_addr = 32'h40;
        cycle();
        if_req = 1'b0; d_req = 1'b1; d_addr = 32'h0000_fffc;
        cycle();
        d_req = 1'b0;
        cycle(); cycle();

        // Reset the cycle after a fetch grant.
        if_req = 1'b1; if_addr = 32'h20;
        cycle();
        if_req = 1'b0;
        assert_reset();
        cycle();
        rst = 1'b0;
        cycle();
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("post_reset_seq", act_d_gnt, (i % 5) != 4);
        end
        if_req = 1'b0; d_req = 1'b0;
        cycle();

        // Randomized traffic; each requester holds its address until granted.
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (!if_req || exp_if_gnt) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = rand_addr();
            end
            if (!d_req || exp_d_gnt) begin
                d_req  = ($urandom_range(0, 2) != 0);
                d_addr = rand_addr();
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        cycle(); cycle(); cycle();
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
